// File: rtl/ex_mem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ex_mem_loader                                                |
// | Description : Initiator for the datapath external memory-load interface.   |
// |               Takes a 32-bit word stream, packs the words per destination  |
// |               memory into {Data1,Data2} pairs and presents each pair       |
// |               atomically at an 8-byte-aligned address while the core is    |
// |               held in load mode. Releases enable_load_ex_mem once the      |
// |               session completes so the core starts fetching from PC=0.     |
// | Ports       : clk, reset (sync, active-low)                                |
// |               start                - begin a load session (IDLE only)      |
// |               s_valid/s_ready/s_data/s_dest/s_last - word stream           |
// |                                      (s_dest 0 = inst mem, 1 = data mem)   |
// |               enable_load_ex_mem   - holds core in load mode               |
// |               InstExMemAddress/Data1/Data2 - instruction pair port         |
// |               DataExMemAddress/Data1/Data2 - data pair port                |
// |               busy, done (1-cycle pulse), ovf (sticky address wrap)        |
// | Options     : LOADER_CHECKSUM_EN adds output checksum, the modulo-2^DATA_W |
// |               sum of every accepted stream word.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ex_mem_loader #(
   parameter int ADDR_W      = 9,
   parameter int DATA_W      = 32,
   parameter int HOLD_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_dest,
   input  logic              s_last,
   output logic              enable_load_ex_mem,
   output logic [ADDR_W-1:0] InstExMemAddress,
   output logic [DATA_W-1:0] InstExMemData1,
   output logic [DATA_W-1:0] InstExMemData2,
   output logic [ADDR_W-1:0] DataExMemAddress,
   output logic [DATA_W-1:0] DataExMemData1,
   output logic [DATA_W-1:0] DataExMemData2,
   output logic              busy,
   output logic              done,
`ifdef LOADER_CHECKSUM_EN
   output logic              ovf,
   output logic [DATA_W-1:0] checksum
`else
   output logic              ovf
`endif
);

   localparam int                c_hold_w    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_CYCLES - 1);
   localparam logic [c_hold_w-1:0] c_hold_one  = c_hold_w'(1);
   // Last 8-byte slot before the address counter wraps to 0.
   localparam logic [ADDR_W-1:0] c_wrap_addr = {{(ADDR_W-3){1'b1}}, 3'b000};
   localparam logic [ADDR_W-1:0] c_pair_step = ADDR_W'(8);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_FLUSH = 3'd2,
      ST_HOLD  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [c_hold_w-1:0] r_hold_cnt;
   logic                r_ovf;
   logic                w_go;
   logic                w_flush;
   logic                w_accept;

   logic [1:0][ADDR_W-1:0] w_pair_addr;
   logic [1:0][DATA_W-1:0] w_pair_lo;
   logic [1:0][DATA_W-1:0] w_pair_hi;
   logic [1:0]             w_wrap_hit;

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next       = r_state;
      s_ready            = 1'b0;
      enable_load_ex_mem = 1'b0;
      busy               = 1'b0;
      done               = 1'b0;
      w_go               = 1'b0;
      w_flush            = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_go         = 1'b1;
               w_state_next = ST_LOAD;
            end
         end
         ST_LOAD: begin
            s_ready            = 1'b1;
            enable_load_ex_mem = 1'b1;
            busy               = 1'b1;
            if (s_valid && s_last) begin
               w_state_next = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            enable_load_ex_mem = 1'b1;
            busy               = 1'b1;
            w_flush            = 1'b1;
            w_state_next       = ST_HOLD;
         end
         ST_HOLD: begin
            enable_load_ex_mem = 1'b1;
            busy               = 1'b1;
            if (r_hold_cnt == c_hold_last) begin
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            done         = 1'b1;
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   assign w_accept = s_valid && s_ready;

   // Counts cycles spent in HOLD; restarts whenever the FSM is elsewhere.
   always_ff @(posedge clk) begin
      if (!reset || (r_state != ST_HOLD)) begin
         r_hold_cnt <= '0;
      end else begin
         r_hold_cnt <= r_hold_cnt + c_hold_one;
      end
   end

   // ------------------------------------------------------------------
   // Per-port pair packers: index 0 = instruction memory, 1 = data memory
   // ------------------------------------------------------------------
   for (genvar gi = 0; gi < 2; gi++) begin : g_port
      localparam logic c_dest = 1'(gi);

      logic [DATA_W-1:0] r_low;
      logic              r_pend;
      logic [ADDR_W-1:0] r_cnt;
      logic [ADDR_W-1:0] r_addr;
      logic [DATA_W-1:0] r_d1;
      logic [DATA_W-1:0] r_d2;
      logic              w_sel;
      logic              w_store;
      logic              w_commit;
      logic [DATA_W-1:0] w_hi;

      assign w_sel    = w_accept && (s_dest == c_dest);
      assign w_store  = w_sel && !r_pend;
      // A pending low word commits either with its partner or, at the end
      // of the session, padded with a zero high word.
      assign w_commit = (w_sel || w_flush) && r_pend;
      assign w_hi     = w_flush ? '0 : s_data;

      always_ff @(posedge clk) begin
         if (!reset || w_go) begin
            r_low  <= '0;
            r_pend <= 1'b0;
            r_cnt  <= '0;
            r_addr <= '0;
            r_d1   <= '0;
            r_d2   <= '0;
         end else begin
            if (w_store) begin
               r_low  <= s_data;
               r_pend <= 1'b1;
            end
            // Address and both data words move together so the memory
            // never sees a half-updated pair.
            if (w_commit) begin
               r_addr <= r_cnt;
               r_d1   <= r_low;
               r_d2   <= w_hi;
               r_cnt  <= r_cnt + c_pair_step;
               r_pend <= 1'b0;
            end
         end
      end

      assign w_pair_addr[gi] = r_addr;
      assign w_pair_lo[gi]   = r_d1;
      assign w_pair_hi[gi]   = r_d2;
      assign w_wrap_hit[gi]  = w_commit && (r_cnt == c_wrap_addr);
   end

   assign InstExMemAddress = w_pair_addr[0];
   assign InstExMemData1   = w_pair_lo[0];
   assign InstExMemData2   = w_pair_hi[0];
   assign DataExMemAddress = w_pair_addr[1];
   assign DataExMemData1   = w_pair_lo[1];
   assign DataExMemData2   = w_pair_hi[1];

   // Sticky wrap flag, cleared only by reset or a new session.
   always_ff @(posedge clk) begin
      if (!reset || w_go) begin
         r_ovf <= 1'b0;
      end else if (|w_wrap_hit) begin
         r_ovf <= 1'b1;
      end
   end

   assign ovf = r_ovf;

`ifdef LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] r_checksum;

   always_ff @(posedge clk) begin
      if (!reset || w_go) begin
         r_checksum <= '0;
      end else if (w_accept) begin
         r_checksum <= r_checksum + s_data;
      end
   end

   assign checksum = r_checksum;
`else
   // Checksum accumulator not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ex_mem_loader                                             |
// | Description : Self-checking bench for ex_mem_loader. A pair-level model    |
// |               predicts, per memory port, the ordered list of pairs a       |
// |               session must write; a monitor collects every pair change     |
// |               seen while enable is high.                                   |
// | Options     : LOADER_CHECKSUM_EN enables the checksum checks.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ex_mem_loader;
   localparam int ADDR_W      = 9;
   localparam int DATA_W      = 32;
   localparam int HOLD_CYCLES = 2;

   typedef logic [ADDR_W+2*DATA_W-1:0] pair_t;

   logic              clk     = 1'b0;
   logic              reset   = 1'b0;
   logic              start   = 1'b0;
   logic              s_valid = 1'b0;
   logic [DATA_W-1:0] s_data  = '0;
   logic              s_dest  = 1'b0;
   logic              s_last  = 1'b0;
   logic              s_ready;
   logic              enable_load_ex_mem;
   logic [ADDR_W-1:0] InstExMemAddress;
   logic [DATA_W-1:0] InstExMemData1;
   logic [DATA_W-1:0] InstExMemData2;
   logic [ADDR_W-1:0] DataExMemAddress;
   logic [DATA_W-1:0] DataExMemData1;
   logic [DATA_W-1:0] DataExMemData2;
   logic              busy;
   logic              done;
   logic              ovf;
`ifdef LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] checksum;
`endif

   ex_mem_loader #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .HOLD_CYCLES (HOLD_CYCLES)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .start              (start),
      .s_valid            (s_valid),
      .s_ready            (s_ready),
      .s_data             (s_data),
      .s_dest             (s_dest),
      .s_last             (s_last),
      .enable_load_ex_mem (enable_load_ex_mem),
      .InstExMemAddress   (InstExMemAddress),
      .InstExMemData1     (InstExMemData1),
      .InstExMemData2     (InstExMemData2),
      .DataExMemAddress   (DataExMemAddress),
      .DataExMemData1     (DataExMemData1),
      .DataExMemData2     (DataExMemData2),
      .busy               (busy),
      .done               (done),
`ifdef LOADER_CHECKSUM_EN
      .ovf                (ovf),
      .checksum           (checksum)
`else
      .ovf                (ovf)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0;
   int errors = 0;

   // ------------------------------------------------------------------
   // Monitor: every change of a port's pair while enable is high is one
   // write the memory sees. The first enabled cycle is compared to zeros.
   // ------------------------------------------------------------------
   pair_t inst_q[$];
   pair_t data_q[$];
   logic  inst_ovf_q[$];
   pair_t mon_prev_i = '0;
   pair_t mon_prev_d = '0;
   pair_t mon_cur_i;
   pair_t mon_cur_d;
   logic  mon_en_prev = 1'b0;

   always @(posedge clk) begin
      #1;
      mon_cur_i = {InstExMemAddress, InstExMemData1, InstExMemData2};
      mon_cur_d = {DataExMemAddress, DataExMemData1, DataExMemData2};
      if (enable_load_ex_mem === 1'b1) begin
         if (mon_cur_i !== (mon_en_prev ? mon_prev_i : pair_t'(0))) begin
            inst_q.push_back(mon_cur_i);
            inst_ovf_q.push_back(ovf);
         end
         if (mon_cur_d !== (mon_en_prev ? mon_prev_d : pair_t'(0))) begin
            data_q.push_back(mon_cur_d);
         end
      end
      mon_prev_i  = mon_cur_i;
      mon_prev_d  = mon_cur_d;
      mon_en_prev = (enable_load_ex_mem === 1'b1);
   end

   // ------------------------------------------------------------------
   // Reference model: words are split per port, then taken two at a time;
   // pair j lives at byte address 8*j modulo the address space.
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] sw_data[$];
   logic              sw_dest[$];
   pair_t             exp_inst[$];
   pair_t             exp_data[$];
   logic [DATA_W-1:0] exp_sum;
   logic              exp_ovf;
   int                last_acc;

   task automatic build_model();
      logic [DATA_W-1:0] pw0[$];
      logic [DATA_W-1:0] pw1[$];
      logic [DATA_W-1:0] hi;
      exp_inst.delete();
      exp_data.delete();
      exp_sum = '0;
      foreach (sw_data[i]) begin
         exp_sum = exp_sum + sw_data[i];
         if (sw_dest[i]) pw1.push_back(sw_data[i]);
         else            pw0.push_back(sw_data[i]);
      end
      for (int j = 0; 2*j < pw0.size(); j++) begin
         hi = (2*j+1 < pw0.size()) ? pw0[2*j+1] : '0;
         exp_inst.push_back({ADDR_W'((8*j) % (1 << ADDR_W)), pw0[2*j], hi});
      end
      for (int j = 0; 2*j < pw1.size(); j++) begin
         hi = (2*j+1 < pw1.size()) ? pw1[2*j+1] : '0;
         exp_data.push_back({ADDR_W'((8*j) % (1 << ADDR_W)), pw1[2*j], hi});
      end
      exp_ovf = (exp_inst.size() > (1 << (ADDR_W-3)) - 1) ||
                (exp_data.size() > (1 << (ADDR_W-3)) - 1);
   endtask

   function automatic logic [DATA_W-1:0] rnd_word();
      logic [DATA_W-1:0] w;
      w = $urandom;
      if (w == '0) w = 1;
      return w;
   endfunction

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic send_word(input logic [DATA_W-1:0] d, input logic dst, input logic lst);
      int n;
      s_valid = 1'b1;
      s_data  = d;
      s_dest  = dst;
      s_last  = lst;
      n = 0;
      while (s_ready !== 1'b1 && n < 50) begin
         step();
         n++;
      end
      if (s_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL send_word_ready: s_ready=%0b required 1 within 50 cycles", s_ready);
      end
      step();
      last_acc = cyc - 1;
      s_valid  = 1'b0;
      s_last   = 1'b0;
   endtask

   // Sends the queued words with random idle gaps; idle cycles carry a
   // random s_last, which must be ignored without s_valid.
   task automatic send_stream();
      for (int i = 0; i < sw_data.size(); i++) begin
         int gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            s_valid = 1'b0;
            s_last  = 1'($urandom_range(0, 1));
            s_data  = $urandom;
            step();
         end
         send_word(sw_data[i], sw_dest[i], i == sw_data.size() - 1);
      end
   endtask

   task automatic wait_done(output int pulses, output int first_cyc);
      pulses    = 0;
      first_cyc = -1;
      for (int n = 0; n < 20; n++) begin
         if (done === 1'b1) begin
            pulses++;
            if (first_cyc < 0) first_cyc = cyc;
         end
         step();
      end
   endtask

   task automatic run_session(output int pulses, output int first_cyc);
      inst_q.delete();
      data_q.delete();
      inst_ovf_q.delete();
      build_model();
      do_start();
      send_stream();
      wait_done(pulses, first_cyc);
   endtask

   // ------------------------------------------------------------------
   // Tests
   // ------------------------------------------------------------------
   task automatic test_reset();
      reset = 1'b0;
      step();
      step();
      checks++;
      if ({s_ready, enable_load_ex_mem, busy, done, ovf} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: {rdy,en,busy,done,ovf}=%b required 00000",
                  {s_ready, enable_load_ex_mem, busy, done, ovf});
      end
      checks++;
      if ({InstExMemAddress, InstExMemData1, InstExMemData2,
           DataExMemAddress, DataExMemData1, DataExMemData2} !== '0) begin
         errors++;
         $display("FAIL reset_ports: inst=%h/%h/%h data=%h/%h/%h required all 0",
                  InstExMemAddress, InstExMemData1, InstExMemData2,
                  DataExMemAddress, DataExMemData1, DataExMemData2);
      end
      reset = 1'b1;
      step();
      checks++;
      if (enable_load_ex_mem !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: en=%b busy=%b required 0 0", enable_load_ex_mem, busy);
      end
   endtask

   task automatic test_basic();
      int pulses, dc;
      inst_q.delete();
      data_q.delete();
      do_start();
      checks++;
      if (enable_load_ex_mem !== 1'b1 || busy !== 1'b1 || InstExMemAddress !== '0) begin
         errors++;
         $display("FAIL basic_start: en=%b busy=%b addr=%h required 1 1 0",
                  enable_load_ex_mem, busy, InstExMemAddress);
      end
      send_word(32'h11, 1'b0, 1'b0);
      send_word(32'h22, 1'b0, 1'b0);
      checks++;
      if ({InstExMemAddress, InstExMemData1, InstExMemData2} !== {9'h0, 32'h11, 32'h22}) begin
         errors++;
         $display("FAIL basic_pair0: got %h/%h/%h required 000/11/22",
                  InstExMemAddress, InstExMemData1, InstExMemData2);
      end
      send_word(32'h33, 1'b0, 1'b0);
      send_word(32'h44, 1'b0, 1'b1);
      checks++;
      if ({InstExMemAddress, InstExMemData1, InstExMemData2} !== {9'h8, 32'h33, 32'h44}) begin
         errors++;
         $display("FAIL basic_pair1: got %h/%h/%h required 008/33/44",
                  InstExMemAddress, InstExMemData1, InstExMemData2);
      end
      wait_done(pulses, dc);
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL basic_done_pulses: got %0d required 1", pulses);
      end
      checks++;
      if (dc - last_acc != HOLD_CYCLES + 2) begin
         errors++;
         $display("FAIL basic_done_latency: got %0d required %0d", dc - last_acc, HOLD_CYCLES + 2);
      end
      checks++;
      if (inst_q.size() != 2 || data_q.size() != 0) begin
         errors++;
         $display("FAIL basic_write_count: inst=%0d data=%0d required 2 0", inst_q.size(), data_q.size());
      end
      checks++;
      if (enable_load_ex_mem !== 1'b0 || busy !== 1'b0 ||
          {DataExMemAddress, DataExMemData1, DataExMemData2} !== '0) begin
         errors++;
         $display("FAIL basic_end_state: en=%b busy=%b data=%h/%h/%h required 0 0 0/0/0",
                  enable_load_ex_mem, busy, DataExMemAddress, DataExMemData1, DataExMemData2);
      end
   endtask

   task automatic test_odd();
      int pulses, dc;
      sw_data = '{32'hA, 32'hB, 32'hC};
      sw_dest = '{1'b1, 1'b1, 1'b1};
      run_session(pulses, dc);
      checks++;
      if (data_q.size() != 2) begin
         errors++;
         $display("FAIL odd_count: got %0d data writes required 2", data_q.size());
      end else begin
         checks++;
         if (data_q[0] !== {9'h0, 32'hA, 32'hB} || data_q[1] !== {9'h8, 32'hC, 32'h0}) begin
            errors++;
            $display("FAIL odd_pairs: got %h %h required (0,A,B) (8,C,0)", data_q[0], data_q[1]);
         end
      end
      checks++;
      if (inst_q.size() != 0 || pulses != 1) begin
         errors++;
         $display("FAIL odd_side: inst writes=%0d done pulses=%0d required 0 1", inst_q.size(), pulses);
      end
   endtask

   task automatic test_interleave();
      int pulses, dc;
      logic [DATA_W-1:0] i0, i1, d0, d1;
      i0 = rnd_word(); i1 = rnd_word(); d0 = rnd_word(); d1 = rnd_word();
      sw_data = '{i0, d0, i1, d1};
      sw_dest = '{1'b0, 1'b1, 1'b0, 1'b1};
      run_session(pulses, dc);
      checks++;
      if (inst_q.size() != 1 || inst_q[0] !== {9'h0, i0, i1}) begin
         errors++;
         $display("FAIL interleave_inst: writes=%0d first=%h required 1 %h",
                  inst_q.size(), (inst_q.size() > 0) ? inst_q[0] : pair_t'(0), {9'h0, i0, i1});
      end
      checks++;
      if (data_q.size() != 1 || data_q[0] !== {9'h0, d0, d1}) begin
         errors++;
         $display("FAIL interleave_data: writes=%0d first=%h required 1 %h",
                  data_q.size(), (data_q.size() > 0) ? data_q[0] : pair_t'(0), {9'h0, d0, d1});
      end
   endtask

   task automatic test_ovf();
      int pulses, dc, bad;
      sw_data.delete();
      sw_dest.delete();
      for (int i = 0; i < 132; i++) begin
         sw_data.push_back(rnd_word());
         sw_dest.push_back(1'b0);
      end
      run_session(pulses, dc);
      checks++;
      if (inst_q.size() != 66) begin
         errors++;
         $display("FAIL ovf_count: got %0d inst writes required 66", inst_q.size());
      end else begin
         bad = 0;
         foreach (exp_inst[j]) if (inst_q[j] !== exp_inst[j]) bad++;
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL ovf_pairs: %0d pairs differ from model, required 0", bad);
         end
         checks++;
         if (inst_q[63][ADDR_W+2*DATA_W-1 -: ADDR_W] !== 9'h1F8 ||
             inst_q[64][ADDR_W+2*DATA_W-1 -: ADDR_W] !== 9'h000) begin
            errors++;
            $display("FAIL ovf_wrap_addr: pair64 addr=%h pair65 addr=%h required 1f8 000",
                     inst_q[63][ADDR_W+2*DATA_W-1 -: ADDR_W], inst_q[64][ADDR_W+2*DATA_W-1 -: ADDR_W]);
         end
         checks++;
         if (inst_ovf_q[62] !== 1'b0 || inst_ovf_q[63] !== 1'b1 || inst_ovf_q[65] !== 1'b1) begin
            errors++;
            $display("FAIL ovf_timing: ovf at pair 63/64/66=%b%b%b required 011",
                     inst_ovf_q[62], inst_ovf_q[63], inst_ovf_q[65]);
         end
      end
      checks++;
      if (ovf !== exp_ovf) begin
         errors++;
         $display("FAIL ovf_sticky: got %b required %b", ovf, exp_ovf);
      end
      do_start();
      checks++;
      if (ovf !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear_on_start: got %b required 0", ovf);
      end
      send_word(rnd_word(), 1'b0, 1'b1);
      wait_done(pulses, dc);
   endtask

   task automatic test_reset_mid();
      int pulses, dc;
      logic [DATA_W-1:0] x, y;
      do_start();
      send_word(rnd_word(), 1'b0, 1'b0);
      send_word(rnd_word(), 1'b0, 1'b0);
      send_word(rnd_word(), 1'b0, 1'b0);
      reset = 1'b0;
      step();
      checks++;
      if ({enable_load_ex_mem, busy, s_ready, done, ovf} !== 5'b0 ||
          {InstExMemAddress, InstExMemData1, InstExMemData2,
           DataExMemAddress, DataExMemData1, DataExMemData2} !== '0) begin
         errors++;
         $display("FAIL reset_mid: en=%b busy=%b inst=%h/%h/%h required 0 0 all 0",
                  enable_load_ex_mem, busy, InstExMemAddress, InstExMemData1, InstExMemData2);
      end
      reset = 1'b1;
      step();
      x = rnd_word();
      y = rnd_word();
      sw_data = '{x, y};
      sw_dest = '{1'b0, 1'b0};
      run_session(pulses, dc);
      checks++;
      if (inst_q.size() != 1 || inst_q[0] !== {9'h0, x, y}) begin
         errors++;
         $display("FAIL reset_mid_clean: writes=%0d first=%h required 1 %h",
                  inst_q.size(), (inst_q.size() > 0) ? inst_q[0] : pair_t'(0), {9'h0, x, y});
      end
   endtask

   task automatic test_busy_start();
      int pulses, dc;
      sw_data = '{32'hFFFF_FFFF, 32'h2, 32'h5, 32'h6};
      sw_dest = '{1'b0, 1'b0, 1'b0, 1'b0};
      build_model();
      do_start();
      send_word(32'hFFFF_FFFF, 1'b0, 1'b0);
      send_word(32'h2, 1'b0, 1'b0);
`ifdef LOADER_CHECKSUM_EN
      checks++;
      if (checksum !== 32'h0000_0001) begin
         errors++;
         $display("FAIL checksum_wrap: got %h required 00000001", checksum);
      end
`endif
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || {InstExMemAddress, InstExMemData1, InstExMemData2} !==
          {9'h0, 32'hFFFF_FFFF, 32'h2}) begin
         errors++;
         $display("FAIL busy_start_hold: busy=%b inst=%h/%h/%h required 1 000/ffffffff/00000002",
                  busy, InstExMemAddress, InstExMemData1, InstExMemData2);
      end
      send_word(32'h5, 1'b0, 1'b0);
      send_word(32'h6, 1'b0, 1'b1);
      checks++;
      if ({InstExMemAddress, InstExMemData1, InstExMemData2} !== {9'h8, 32'h5, 32'h6}) begin
         errors++;
         $display("FAIL busy_start_ignored: got %h/%h/%h required 008/5/6",
                  InstExMemAddress, InstExMemData1, InstExMemData2);
      end
      wait_done(pulses, dc);
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL busy_start_done: got %0d pulses required 1", pulses);
      end
`ifdef LOADER_CHECKSUM_EN
      checks++;
      if (checksum !== exp_sum) begin
         errors++;
         $display("FAIL checksum_hold: got %h required %h", checksum, exp_sum);
      end
`endif
   endtask

   task automatic test_random();
      int pulses, dc, n;
      for (int s = 0; s < 6; s++) begin
         n = $urandom_range(1, 24);
         sw_data.delete();
         sw_dest.delete();
         for (int i = 0; i < n; i++) begin
            sw_data.push_back(rnd_word());
            sw_dest.push_back(1'($urandom_range(0, 1)));
         end
         run_session(pulses, dc);
         checks++;
         if (inst_q.size() != exp_inst.size() || data_q.size() != exp_data.size()) begin
            errors++;
            $display("FAIL rand%0d_counts: inst=%0d data=%0d required %0d %0d",
                     s, inst_q.size(), data_q.size(), exp_inst.size(), exp_data.size());
         end else begin
            foreach (exp_inst[j]) begin
               checks++;
               if (inst_q[j] !== exp_inst[j]) begin
                  errors++;
                  $display("FAIL rand%0d_inst%0d: got %h required %h", s, j, inst_q[j], exp_inst[j]);
               end
            end
            foreach (exp_data[j]) begin
               checks++;
               if (data_q[j] !== exp_data[j]) begin
                  errors++;
                  $display("FAIL rand%0d_data%0d: got %h required %h", s, j, data_q[j], exp_data[j]);
               end
            end
         end
         checks++;
         if (pulses != 1 || ovf !== exp_ovf || busy !== 1'b0) begin
            errors++;
            $display("FAIL rand%0d_end: pulses=%0d ovf=%b busy=%b required 1 %b 0",
                     s, pulses, ovf, busy, exp_ovf);
         end
`ifdef LOADER_CHECKSUM_EN
         checks++;
         if (checksum !== exp_sum) begin
            errors++;
            $display("FAIL rand%0d_checksum: got %h required %h", s, checksum, exp_sum);
         end
`endif
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_odd();
      test_interleave();
      test_ovf();
      test_reset_mid();
      test_busy_start();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
